lane_word_packer: RTL and testbench
===================================

// Module: lane_word_packer
// PURPOSE
//  Parametrised, sequential successor to the fixed four-input concatenator.
//  Accepts one LANE_W-bit chunk per valid/ready beat and packs LANES chunks into one OUT_W-bit word.
//  Supports MSB-first or LSB-first lane order, early flush with zero padding, and full output backpressure.
//  Used between byte-wide sources (loader, debug/UART path) and word-wide pipeline/memory consumers.
// PARAMETERS
//  LANE_W   8   width of one input chunk (>=1)
//  LANES    4   chunks per output word (>=2)
//  OUT_W    LANE_W*LANES  localparam, output word width; lane i = out_data[i*LANE_W +: LANE_W]
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input chunk valid
//  in_ready   out  1        packer can accept a chunk
//  in_data    in   LANE_W   input chunk
//  in_last    in   1        chunk closes the word early (flush, pad remaining lanes with 0)
//  mode       in   1        0: MSB-first (beat k -> lane LANES-1-k); 1: LSB-first (beat k -> lane k)
//  out_valid  out  1        packed word valid
//  out_ready  in   1        consumer accepts word
//  out_data   out  OUT_W    packed word
//  out_mask   out  LANES    bit i set = lane i holds received data
//  out_partial out 1        word closed by in_last before all lanes were filled
// BEHAVIOUR
//  Reset (async, rst_n=0): state=ACCUM, fill=0, accumulator=0, out_valid=0, out_data=0,
//   out_mask=0, out_partial=0, in_ready=1. Deassertion is synchronised by the top-level reset logic.
//  Beat accepted when in_valid&&in_ready; word accepted when out_valid&&out_ready.
//  fill counter: 0..LANES-1, $clog2(LANES) bits; counts chunks in the accumulator.
//  mode is sampled on the beat with fill==0 and held for the whole word; changes mid-word are ignored.
//  Each accepted chunk is written to its lane and sets the matching mask bit. Lanes not written are 0.
//  Completing beat = accepted beat with fill==LANES-1 OR in_last=1.
//  FSM:
//   ACCUM: in_ready=1.
//    Non-completing beat: fill++.
//    Completing beat with output slot free (!out_valid || out_ready this cycle): the word (incl.
//     this chunk) moves to the output registers; out_valid=1 next cycle; fill=0; accumulator/mask
//     clear; stay ACCUM.
//    Completing beat with slot busy: chunk stored in accumulator, go to HOLD.
//   HOLD: in_ready=0. When !out_valid || out_ready: move accumulator to output, clear it,
//    fill=0, go to ACCUM next cycle.
//  Latency: out_valid rises on the cycle after the completing beat (ACCUM) or the slot-free cycle (HOLD).
//  Full throughput: with out_ready=1 continuously, one word per LANES beats, no bubbles.
//  Output stability: out_data/out_mask/out_partial are held unchanged while out_valid=1 && out_ready=0.
//   out_valid drops the cycle after acceptance unless a new word loads in the same cycle
//   (back-to-back load allowed).
//  out_partial = 1 iff out_mask != all-ones.
//  in_last with fill==LANES-1 is a normal full word (out_partial=0).
//  in_last on the first beat gives a single-lane word.
//  in_ready never depends combinationally on in_valid, in_data or in_last; it depends only on state.
//  Reset mid-word or mid-HOLD discards all buffered data; no partial word is emitted.
// TESTING (LANE_W=8, LANES=4)
//  1. mode=0, beats AA,BB,CC,DD back-to-back, out_ready=1 -> out_data=32'hAABBCCDD, mask=4'hF,
//     partial=0, out_valid 1 cycle after DD.
//  2. mode=1, same beats -> out_data=32'hDDCCBBAA, mask=4'hF.
//  3. mode=0, beats 11,22 with in_last on 22 -> out_data=32'h11220000, mask=4'b1100, partial=1.
//  4. out_ready=0, stream 8 beats 01..08 -> word1=32'h01020304 held stable; after 08 in_ready=0 (HOLD);
//     out_ready=1 for one cycle -> out_data=32'h05060708 next cycle, in_ready=1.
//  5. Two beats, then rst_n=0 for 1 cycle -> all outputs 0; then beats A1..A4 -> 32'hA1A2A3A4,
//     no leftover lanes.
//  6. mode toggled 0->1 after first beat of 10,20,30,40 -> still 32'h10203040; sustained 12 beats with
//     out_ready=1 -> 3 words, in_ready never low.

Source files
------------

// File: rtl/lane_word_packer.sv
// ============================================================================
// Module   : lane_word_packer
// Purpose  : Packs LANES chunks of LANE_W bits into one word, with selectable
//            lane order, early flush with zero padding and output backpressure.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lane_word_packer #(
  parameter  int LANE_W = 8,
  parameter  int LANES  = 4,
  localparam int OUT_W  = LANE_W * LANES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANE_W-1:0]  in_data,
  input  logic               in_last,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [LANES-1:0]   out_mask,
  output logic               out_partial
);

  localparam int                  c_fill_w    = $clog2(LANES);
  localparam logic [c_fill_w-1:0] c_last_fill = c_fill_w'(LANES - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_fill_w-1:0] r_fill;
  logic [OUT_W-1:0]    r_acc;
  logic [LANES-1:0]    r_mask;
  logic                r_mode;
  logic                r_out_valid;
  logic [OUT_W-1:0]    r_out_data;
  logic [LANES-1:0]    r_out_mask;
  logic                r_out_partial;

  logic                w_in_ready;
  logic                w_mode_eff;
  logic [c_fill_w-1:0] w_lane;
  logic [OUT_W-1:0]    w_acc_next;
  logic [LANES-1:0]    w_mask_next;
  logic                w_beat;
  logic                w_complete;
  logic                w_slot_free;
  logic                w_load_beat;
  logic                w_load_hold;
  logic [OUT_W-1:0]    w_ld_data;
  logic [LANES-1:0]    w_ld_mask;

  assign w_in_ready  = (r_state == ST_ACCUM);
  assign w_beat      = in_valid && w_in_ready;
  assign w_complete  = w_beat && ((r_fill == c_last_fill) || in_last);
  assign w_slot_free = !r_out_valid || out_ready;

  // Lane order is taken from the live input only on the first chunk of a word.
  assign w_mode_eff = (r_fill == '0) ? mode : r_mode;
  assign w_lane     = w_mode_eff ? r_fill : (c_last_fill - r_fill);

  always_comb begin
    w_acc_next  = r_acc;
    w_mask_next = r_mask;
    for (int i = 0; i < LANES; i++) begin
      if (w_lane == c_fill_w'(i)) begin
        w_acc_next[i*LANE_W +: LANE_W] = in_data;
        w_mask_next[i]                 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_beat  = 1'b0;
    w_load_hold  = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_complete) begin
          if (w_slot_free) begin
            w_load_beat = 1'b1;
          end else begin
            w_state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_slot_free) begin
          w_load_hold  = 1'b1;
          w_state_next = ST_ACCUM;
        end
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  assign w_ld_data = w_load_beat ? w_acc_next  : r_acc;
  assign w_ld_mask = w_load_beat ? w_mask_next : r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill        <= '0;
      r_acc         <= '0;
      r_mask        <= '0;
      r_mode        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_mask    <= '0;
      r_out_partial <= 1'b0;
    end else if (w_load_beat || w_load_hold) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= w_ld_data;
      r_out_mask    <= w_ld_mask;
      r_out_partial <= ~&w_ld_mask;
      r_acc         <= '0;
      r_mask        <= '0;
      r_fill        <= '0;
    end else begin
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // A completing beat that finds the slot busy parks here until HOLD drains it.
      if (w_beat) begin
        r_acc  <= w_acc_next;
        r_mask <= w_mask_next;
        if (!w_complete) begin
          r_fill <= r_fill + c_fill_w'(1);
        end
        if (r_fill == '0) begin
          r_mode <= mode;
        end
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_mask    = r_out_mask;
  assign out_partial = r_out_partial;

endmodule

`default_nettype wire

// File: tb/tb_lane_word_packer.sv
// ============================================================================
// Module   : tb_lane_word_packer
// Purpose  : Self-checking bench for lane_word_packer against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lane_word_packer;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int OUT_W  = LANE_W * LANES;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LANE_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              mode = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic [LANES-1:0]  out_mask;
  logic              out_partial;

  lane_word_packer #(.LANE_W(LANE_W), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_partial(out_partial)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [LANES-1:0] mask;
    logic             partial;
  } word_t;

  int    total = 0;
  int    bad = 0;
  int    words_out = 0;
  int    stalls = 0;
  bit    rnd_done = 1'b0;
  word_t q[$];

  // Model of the word being assembled: beat count, sampled order, contents.
  int               m_k = 0;
  bit               m_mode = 1'b0;
  logic [OUT_W-1:0] m_word = '0;
  logic [LANES-1:0] m_mask = '0;

  task automatic chk(string name, logic [OUT_W-1:0] act, logic [OUT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshakes are evaluated mid-cycle, where inputs and DUT outputs are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_k = 0; m_word = '0; m_mask = '0;
      chk("reset_outs", {out_valid, out_partial, out_mask, out_data[25:0]}, '0);
      chk("reset_ready", OUT_W'(in_ready), 1);
    end else begin
      chk("out_valid", OUT_W'(out_valid), OUT_W'(q.size() > 0));
      chk("in_ready", OUT_W'(in_ready), OUT_W'(q.size() < 2));
      if (out_valid && q.size() > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_mask", OUT_W'(out_mask), OUT_W'(q[0].mask));
        chk("out_partial", OUT_W'(out_partial), OUT_W'(q[0].partial));
        if (out_ready) begin
          void'(q.pop_front());
          words_out++;
        end
      end
      if (in_valid && in_ready) begin
        int lane;
        word_t w;
        if (m_k == 0) m_mode = mode;
        lane   = m_mode ? m_k : LANES - 1 - m_k;
        m_word = m_word | (OUT_W'(in_data) << (lane * LANE_W));
        m_mask = m_mask | (LANES'(1) << lane);
        m_k++;
        if (m_k == LANES || in_last) begin
          w.data = m_word; w.mask = m_mask; w.partial = (m_mask != '1);
          q.push_back(w);
          m_k = 0; m_word = '0; m_mask = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(logic [7:0] d, bit last, bit m);
    in_valid = 1'b1; in_data = d; in_last = last; mode = m;
    for (int t = 0; t < 200 && !in_ready; t++) begin
      stalls++;
      tick();
    end
    if (!in_ready) chk("beat_timeout", OUT_W'(in_ready), 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_word(string name, logic [31:0] d, logic [3:0] m, bit p);
    chk({name, "_valid"}, OUT_W'(out_valid), 1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_mask"}, OUT_W'(out_mask), OUT_W'(m));
    chk({name, "_partial"}, OUT_W'(out_partial), OUT_W'(p));
  endtask

  initial begin
    int base;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Full word, MSB-first then LSB-first; result visible the cycle after DD.
    beat(8'hAA, 0, 0); beat(8'hBB, 0, 0); beat(8'hCC, 0, 0); beat(8'hDD, 0, 0);
    chk_word("t1", 32'hAABBCCDD, 4'hF, 0);
    beat(8'hAA, 0, 1); beat(8'hBB, 0, 1); beat(8'hCC, 0, 1); beat(8'hDD, 0, 1);
    chk_word("t2", 32'hDDCCBBAA, 4'hF, 0);

    beat(8'h11, 0, 0); beat(8'h22, 1, 0);
    chk_word("t3", 32'h11220000, 4'b1100, 1);
    beat(8'h33, 1, 1);
    chk_word("t3b", 32'h00000033, 4'b0001, 1);
    beat(8'h01, 0, 0); beat(8'h02, 0, 0); beat(8'h03, 0, 0); beat(8'h04, 1, 0);
    chk_word("t3c", 32'h01020304, 4'hF, 0);
    tick();

    // Backpressure: second word parks in HOLD, first stays stable.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) beat(8'(i), 0, 0);
    chk("t4_hold_ready", OUT_W'(in_ready), 0);
    repeat (3) tick();
    chk_word("t4_w1", 32'h01020304, 4'hF, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_word("t4_w2", 32'h05060708, 4'hF, 0);
    chk("t4_ready", OUT_W'(in_ready), 1);
    out_ready = 1'b1;
    tick();

    // Reset mid-word discards buffered lanes.
    beat(8'hE1, 0, 0); beat(8'hE2, 0, 0);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_valid", OUT_W'(out_valid), 0);
    rst_n = 1'b1;
    tick();
    beat(8'hA1, 0, 0); beat(8'hA2, 0, 0); beat(8'hA3, 0, 0); beat(8'hA4, 0, 0);
    chk_word("t5", 32'hA1A2A3A4, 4'hF, 0);

    // Mode change mid-word is ignored; then sustained full throughput.
    beat(8'h10, 0, 0); beat(8'h20, 0, 1); beat(8'h30, 0, 1); beat(8'h40, 0, 1);
    chk_word("t6", 32'h10203040, 4'hF, 0);
    tick();
    base = words_out;
    stalls = 0;
    for (int i = 0; i < 12; i++) beat(8'($urandom), 0, 1);
    tick();
    chk("t6_words", OUT_W'(words_out - base), 3);
    chk("t6_stalls", OUT_W'(stalls), 0);

    // Random traffic with random backpressure and one mid-run reset.
    fork
      begin
        for (int n = 0; n < 1500; n++) begin
          repeat ($urandom_range(0, 2)) tick();
          if (n == 700) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
          end
          beat(8'($urandom), $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    out_ready = 1'b1;
    repeat (4) tick();
    chk("drain_empty", OUT_W'(q.size()), 0);
    chk("drain_valid", OUT_W'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
